// File: rtl/mul11_rr_scheduler_if.sv
// Request/result bundle for mul11_rr_scheduler.
// req_*: NUM_REQ operand ports; out_*: product stream; busy: pipe occupied.
interface mul11_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*11-1:0] req_a;
  logic [NUM_REQ*11-1:0] req_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [21:0]           out_prod;
  logic [ID_W-1:0]       out_id;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b,
    output out_ready,
    input  req_ready, out_valid,
    input  out_prod, out_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b,
    input  out_ready,
    output req_ready, out_valid,
    output out_prod, out_id, busy
  );
endinterface

// File: rtl/mul11_rr_scheduler.sv
// Round-robin share of one 11x11 multiplier, two-stage pipe.
// Ports: clk, rst_n (async low), bus (slave modport of the _if).
module multiplier_11 (
  input  logic [10:0] A_in,
  input  logic [10:0] B_in,
  output logic [21:0] OUT
);
  assign OUT = {11'b0, A_in} * {11'b0, B_in};
endmodule

module mul11_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input logic clk,
  input logic rst_n,
  mul11_rr_scheduler_if.slave bus
);
  logic            s1_v_q, s1_v_d;
  logic [10:0]     s1_a_q, s1_a_d;
  logic [10:0]     s1_b_q, s1_b_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;
  logic            s2_v_q, s2_v_d;
  logic [21:0]     s2_prod_q, s2_prod_d;
  logic [ID_W-1:0] s2_id_q, s2_id_d;
  logic [ID_W-1:0] rr_q, rr_d;

  logic            found;
  logic [ID_W-1:0] win;
  logic [10:0]     sel_a, sel_b;
  logic            s2_load, s1_free, accept;
  logic [21:0]     mul_out;

  // Two passes: indices at/after rr_q first, then wrap to the rest.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req_valid[i] &&
          i >= int'(rr_q)) begin
        found = 1'b1;
        win   = ID_W'(i);
        sel_a = bus.req_a[11*i +: 11];
        sel_b = bus.req_b[11*i +: 11];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req_valid[i]) begin
        found = 1'b1;
        win   = ID_W'(i);
        sel_a = bus.req_a[11*i +: 11];
        sel_b = bus.req_b[11*i +: 11];
      end
    end
  end

  assign s2_load = s1_v_q && (!s2_v_q || bus.out_ready);
  assign s1_free = !s1_v_q || s2_load;
  assign accept  = rst_n && found && s1_free;

  multiplier_11 u_mul (
    .A_in (s1_a_q),
    .B_in (s1_b_q),
    .OUT  (mul_out)
  );

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    s1_id_d   = s1_id_q;
    s2_v_d    = s2_v_q;
    s2_prod_d = s2_prod_q;
    s2_id_d   = s2_id_q;
    rr_d      = rr_q;
    if (accept) begin
      s1_v_d  = 1'b1;
      s1_a_d  = sel_a;
      s1_b_d  = sel_b;
      s1_id_d = win;
      rr_d    = (win == ID_W'(NUM_REQ-1)) ?
                '0 : win + 1'b1;
    end else if (s2_load) begin
      s1_v_d = 1'b0;
    end
    if (s2_load) begin
      s2_v_d    = 1'b1;
      s2_prod_d = mul_out;
      s2_id_d   = s1_id_q;
    end else if (bus.out_ready) begin
      s2_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_id_q   <= '0;
      s2_v_q    <= 1'b0;
      s2_prod_q <= '0;
      s2_id_q   <= '0;
      rr_q      <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_id_q   <= s1_id_d;
      s2_v_q    <= s2_v_d;
      s2_prod_q <= s2_prod_d;
      s2_id_q   <= s2_id_d;
      rr_q      <= rr_d;
    end
  end

  // Ready is held low during reset so nothing looks accepted.
  assign bus.req_ready = accept ?
    ({{(NUM_REQ-1){1'b0}}, 1'b1} << win) : '0;
  assign bus.out_valid = s2_v_q;
  assign bus.out_prod  = s2_prod_q;
  assign bus.out_id    = s2_id_q;
  assign bus.busy      = s1_v_q | s2_v_q;
endmodule
